// File: rtl/prbs31_checker.sv
// prbs31_checker -- PRBS31 (x^31 + x^28 + 1) receive-side bit-error checker.
//
// Self-synchronises to a serial PRBS31 stream, then free-runs a local
// reference and counts bit errors against it. Lock is dropped when too many
// errors land inside one observation window.
//
// Ports
//   clk, rst_n   single clock, asynchronous active-low reset
//   ena          ignored
//   ui_in        [0] rx_data [1] rx_valid [2] clr [3] invert [4] relock
//                [5] reserved [7:6] out_sel
//   uio_in       [0] loopback select, [1] error inject (loopback build only)
//   uo_out       readback: 00 err_cnt[7:0], 01 err_cnt[15:8],
//                10 {4'b0, sat, locked, state}, 11 loss_cnt
//   uio_out      [0] locked [1] err_pulse [2] sat, rest 0
//   uio_oe       constant 8'h07
//
// Optional feature: define PRBS31_CHK_LOOPBACK_EN to add an internal PRBS31
// generator that can be routed to the checker input via uio_in[0].
module prbs31_checker #(
  parameter int LOCK_COUNT  = 64,
  parameter int WINDOW      = 256,
  parameter int LOSS_THRESH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int WB = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int EB = $clog2(WINDOW + 1);
  localparam logic [7:0]    LOCK_C   = 8'(LOCK_COUNT);
  localparam logic [WB-1:0] WIN_LAST = WB'(WINDOW - 1);
  localparam logic [EB-1:0] LOSS_C   = EB'(LOSS_THRESH);

  typedef enum logic [1:0] {FILL = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [30:0]   sr_q, sr_d;
  logic [4:0]    fill_q, fill_d;
  logic [7:0]    run_q, run_d;
  logic [WB-1:0] wbit_q, wbit_d;
  logic [EB-1:0] werr_q, werr_d;
  logic [15:0]   err_q, err_d;
  logic          sat_q, sat_d;
  logic [7:0]    loss_q, loss_d;
  logic          pulse_q, pulse_d;

  logic       rx_bit, rx_vld;
  logic       clr, relock, locked;
  logic [1:0] out_sel;

  assign clr     = ui_in[2];
  assign relock  = ui_in[4];
  assign out_sel = ui_in[7:6];

`ifdef PRBS31_CHK_LOOPBACK_EN
  // Internal generator advances every clock regardless of rx_valid.
  logic [30:0] gen_q;
  logic        gen_bit;
  assign gen_bit = gen_q[30] ^ gen_q[27];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) gen_q <= 31'h7FFF_FFFF;
    else        gen_q <= {gen_q[29:0], gen_bit};

  assign rx_bit = uio_in[0] ? (gen_bit ^ uio_in[1]) : (ui_in[0] ^ ui_in[3]);
  assign rx_vld = uio_in[0] | ui_in[1];
`else
  assign rx_bit = ui_in[0] ^ ui_in[3];
  assign rx_vld = ui_in[1];
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[5], uio_in};

  logic        pred;
  logic [30:0] sr_in;
  assign pred  = sr_q[30] ^ sr_q[27];
  assign sr_in = {sr_q[29:0], rx_bit};

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      sr_q    <= '0;
      fill_q  <= '0;
      run_q   <= '0;
      wbit_q  <= '0;
      werr_q  <= '0;
      err_q   <= '0;
      sat_q   <= 1'b0;
      loss_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      wbit_q  <= wbit_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      loss_q  <= loss_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    fill_d  = fill_q;
    run_d   = run_q;
    wbit_d  = wbit_q;
    werr_d  = werr_q;
    err_d   = err_q;
    sat_d   = sat_q;
    loss_d  = loss_q;
    pulse_d = 1'b0;

    if (relock) begin
      // Incoming bit on this edge is dropped.
      state_d = FILL;
      fill_d  = '0;
      run_d   = '0;
      wbit_d  = '0;
      werr_d  = '0;
    end else if (rx_vld) begin
      case (state_q)
        FILL: begin
          sr_d = sr_in;
          if (fill_q == 5'd30) begin
            state_d = SYNC;
            fill_d  = '0;
            run_d   = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        SYNC: begin
          sr_d  = sr_in;
          run_d = (rx_bit == pred) ? run_q + 8'd1 : '0;
          if (run_d == LOCK_C) begin
            // An all-zero history also "matches" forever; refuse to lock on it.
            if (sr_in != '0) begin
              state_d = LOCKED;
              wbit_d  = '0;
              werr_d  = '0;
            end else begin
              run_d = '0;
            end
          end
        end
        LOCKED: begin
          // Feed back the prediction so a line error is seen exactly once.
          sr_d   = {sr_q[29:0], pred};
          wbit_d = wbit_q + WB'(1);
          if (rx_bit != pred) begin
            pulse_d = 1'b1;
            werr_d  = werr_q + EB'(1);
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_d == 16'hFFFF) sat_d = 1'b1;
          end
          if (werr_d >= LOSS_C) begin
            state_d = FILL;
            werr_d  = '0;
            wbit_d  = '0;
            run_d   = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end else if (wbit_q == WIN_LAST) begin
            werr_d = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end

    // clr overrides any same-edge error count.
    if (clr) begin
      err_d  = '0;
      sat_d  = 1'b0;
      loss_d = '0;
    end
  end

  // Outputs
  always_comb begin
    locked = (state_q == LOCKED);
    case (out_sel)
      2'b00:   uo_out = err_q[7:0];
      2'b01:   uo_out = err_q[15:8];
      2'b10:   uo_out = {4'b0, sat_q, locked, state_q};
      default: uo_out = loss_q;
    endcase
    uio_out = {5'b0, sat_q, pulse_q, locked};
    uio_oe  = 8'h07;
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: directed scenarios plus a randomized phase, all
// compared against a behavioural model that keeps the received history as a
// queue of bits and applies the checker's rules with plain arithmetic.
module tb_prbs31_checker;

  localparam int LOCK_COUNT  = 64;
  localparam int WINDOW      = 256;
  localparam int LOSS_THRESH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  prbs31_checker #(
    .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- transmitter ----------------
  logic [30:0] tx_s = 31'h7FFF_FFFF;
  function automatic bit tx_bit();
    bit b;
    b = tx_s[30] ^ tx_s[27];
    tx_s = {tx_s[29:0], b};
    return b;
  endfunction

  // ---------------- reference model ----------------
  int m_st, m_fill, m_run, m_wpos, m_werr, m_err, m_loss;
  bit m_sat, m_pulse;
  bit h[$];   // last 31 bits of history, h[0] oldest

  task automatic model_reset();
    m_st = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
    m_err = 0; m_loss = 0; m_sat = 0; m_pulse = 0;
    h.delete();
    for (int i = 0; i < 31; i++) h.push_back(1'b0);
  endtask

  function automatic bit hist_nonzero();
    for (int i = 0; i < h.size(); i++) if (h[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_hist(input bit b);
    h.push_back(b);
    void'(h.pop_front());
  endtask

  task automatic model_step(input bit vld, input bit r, input bit clr, input bit rl);
    bit p;
    m_pulse = 0;
    if (rl) begin
      m_st = 0; m_fill = 0; m_run = 0; m_wpos = 0; m_werr = 0;
    end else if (vld) begin
      p = h[0] ^ h[3];   // b[n] = b[n-31] ^ b[n-28]
      if (m_st == 0) begin
        push_hist(r);
        m_fill++;
        if (m_fill == 31) begin m_st = 1; m_fill = 0; m_run = 0; end
      end else if (m_st == 1) begin
        push_hist(r);
        m_run = (r == p) ? m_run + 1 : 0;
        if (m_run == LOCK_COUNT) begin
          if (hist_nonzero()) begin m_st = 2; m_wpos = 0; m_werr = 0; end
          else m_run = 0;
        end
      end else begin
        push_hist(p);
        m_wpos++;
        if (r != p) begin
          m_pulse = 1;
          m_werr++;
          if (!clr && m_err < 65535) begin
            m_err++;
            if (m_err == 65535) m_sat = 1;
          end
        end
        if (m_werr >= LOSS_THRESH) begin
          m_st = 0; m_werr = 0; m_wpos = 0; m_run = 0;
          if (m_loss < 255) m_loss++;
        end else if (m_wpos == WINDOW) begin
          m_wpos = 0; m_werr = 0;
        end
      end
    end
    if (clr) begin m_err = 0; m_sat = 0; m_loss = 0; end
  endtask

  function automatic logic [7:0] exp_uo(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_err[7:0];
      2'd1:    return m_err[15:8];
      2'd2:    return {4'b0, m_sat, (m_st == 2), 2'(m_st)};
      default: return m_loss[7:0];
    endcase
  endfunction

  // One clock: drive inputs, step the model, compare after the edge.
  task automatic cyc(input bit rx, input bit vld, input bit clr, input bit rl,
                     input bit inv, input logic [1:0] sel);
    ui_in = {sel, 1'b0, rl, inv, clr, vld, rx ^ inv};
    @(posedge clk);
    model_step(vld, rx, clr, rl);
    #1;
    chk("locked", uio_out[0], (m_st == 2));
    chk("err_pulse", uio_out[1], m_pulse);
    chk("uo_out", uo_out, exp_uo(sel));
  endtask

  task automatic rd(input logic [1:0] sel, output logic [7:0] v);
    ui_in[7:6] = sel;
    #1;
    v = uo_out;
  endtask

  task automatic send_clean(input int n, output int lock_at);
    lock_at = -1;
    for (int i = 1; i <= n; i++) begin
      cyc(tx_bit(), 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
      if (uio_out[0] && lock_at < 0) lock_at = i;
    end
  endtask

  initial begin
    logic [7:0] v;
    int lock_at, npulse, ever;
    bit b, vld, fl, inv, cl, rl;

    ena = 1'b1; ui_in = '0; uio_in = '0; rst_n = 1'b0;
    model_reset();
    #12;
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v);
      chk("reset_uo", v, 8'h00);
    end
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h07);
    @(negedge clk) rst_n = 1'b1;

    // Clean stream from reset: lock on bit 31+LOCK_COUNT.
    send_clean(200, lock_at);
    chk("lock_bit", lock_at, 95);
    rd(2'b10, v); chk("status_locked", v, 8'h06);
    rd(2'b00, v); chk("err_clean", v, 8'h00);

    // Three isolated flips: each counted once.
    npulse = 0;
    for (int i = 1; i <= 130; i++) begin
      fl = (i == 20 || i == 60 || i == 100);
      cyc(tx_bit() ^ fl, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      npulse += int'(uio_out[1]);
    end
    chk("pulse_count", npulse, 3);
    rd(2'b00, v); chk("err_cnt_3", v, 8'h03);
    chk("still_locked", uio_out[0], 1'b1);

    // Randomized: valid gaps, invert, sparse errors, occasional clr/relock.
    for (int i = 0; i < 4000; i++) begin
      vld = ($urandom_range(3) != 0);
      inv = $urandom_range(1);
      fl  = ($urandom_range(199) == 0);
      cl  = ($urandom_range(499) == 0);
      rl  = ($urandom_range(999) == 0);
      b   = vld ? (tx_bit() ^ fl) : 1'($urandom);
      cyc(b, vld, cl, rl, inv, 2'($urandom));
    end

    // Loss of lock: 16 errors inside one window right after a fresh lock.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    send_clean(95, lock_at);
    chk("relock_bit", lock_at, 95);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11);
    for (int k = 1; k <= 64; k++) begin
      fl = (k % 4 == 0);
      cyc(tx_bit() ^ fl, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11);
      if (k == 63) chk("locked_before_16th", uio_out[0], 1'b1);
      if (k == 64) chk("unlocked_on_16th", uio_out[0], 1'b0);
    end
    rd(2'b11, v); chk("loss_cnt", v, 8'h01);
    send_clean(95, lock_at);
    chk("relock_after_loss", lock_at, 95);
    rd(2'b00, v); chk("err_cnt_16", v, 8'h10);
    // clr together with an error: error is not counted.
    cyc(tx_bit() ^ 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
    rd(2'b00, v); chk("clr_wins_lo", v, 8'h00);
    rd(2'b01, v); chk("clr_wins_hi", v, 8'h00);

    // All-zeros input never locks.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    ever = 0;
    for (int i = 0; i < 500; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10);
      ever |= int'(uio_out[0]);
    end
    chk("zeros_never_lock", ever, 0);
    rd(2'b10, v); chk("zeros_state_sync", v, 8'h01);

    // Asynchronous reset while locked with a nonzero error count.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    send_clean(95, lock_at);
    cyc(tx_bit() ^ 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    chk("pre_reset_err", uo_out, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_locked", uio_out[0], 1'b0);
    chk("async_err", uo_out, 8'h00);
    chk("async_uio_out", uio_out, 8'h00);
    chk("async_uio_oe", uio_oe, 8'h07);

`ifdef PRBS31_CHK_LOOPBACK_EN
    ui_in = '0; uio_in = 8'h01;
    @(negedge clk) rst_n = 1'b1;
    for (int i = 1; i <= 95; i++) begin
      @(posedge clk); #1;
      if (i == 94) chk("lb_not_yet", uio_out[0], 1'b0);
      if (i == 95) chk("lb_locked", uio_out[0], 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      uio_in = 8'h03;
      @(posedge clk); #1;
      uio_in = 8'h01;
      repeat (30) @(posedge clk);
      #1;
    end
    rd(2'b00, v); chk("lb_err_cnt", v, 8'h05);
    chk("lb_still_locked", uio_out[0], 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
